sevenseg_scan: RTL



---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/sevenseg_scan_if.sv | 21 ++
 rtl/sevenseg_scan_bcd_to_7seg.sv | 28 ++
 rtl/sevenseg_scan.sv | 92 +++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch slice: BCD digit type, the active-low
// seven-segment glyph constants ({g,f,e,d,c,b,a}, 0 = segment lit) and the
// system clock frequency.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam int unsigned CLK_HZ = 100_000_000;

    localparam seg_t SEG_0    = 7'b1000000;
    localparam seg_t SEG_1    = 7'b1111001;
    localparam seg_t SEG_2    = 7'b0100100;
    localparam seg_t SEG_3    = 7'b0110000;
    localparam seg_t SEG_4    = 7'b0011001;
    localparam seg_t SEG_5    = 7'b0010010;
    localparam seg_t SEG_6    = 7'b0000010;
    localparam seg_t SEG_7    = 7'b1111000;
    localparam seg_t SEG_8    = 7'b0000000;
    localparam seg_t SEG_9    = 7'b0010000;
    localparam seg_t SEG_DASH = 7'b0111111;
    localparam seg_t SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/sevenseg_scan_if.sv
// Digit/display bundle for sevenseg_scan.
//   d0..d3 : BCD digits (tenths, seconds, tens of seconds, minutes)
//   an     : anode enables, active low, an[3] = leftmost digit
//   seg    : segment cathodes, active low, seg[0]=a .. seg[6]=g
//   dp     : decimal point cathode, active low
// master = digit source / display side, slave = the scanner.
interface sevenseg_scan_if;
    import stopwatch_pkg::*;

    bcd_t       d0;
    bcd_t       d1;
    bcd_t       d2;
    bcd_t       d3;
    logic [3:0] an;
    seg_t       seg;
    logic       dp;

    modport master (output d0, d1, d2, d3, input an, seg, dp);
    modport slave  (input d0, d1, d2, d3, output an, seg, dp);

endinterface

// File: rtl/sevenseg_scan_bcd_to_7seg.sv
// Pure combinational BCD to active-low seven-segment decoder.
//   bcd : input digit
//   seg : active-low segments {g..a}; values 10-15 render as a dash
module bcd_to_7seg
    import stopwatch_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Four-digit time-multiplexed driver for a common-anode seven-segment display.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : digits in, active-low an/seg/dp out (see sevenseg_scan_if)
// Each digit owns REFRESH_DIV cycles; the first BLANK_CYCLES of a slot keep
// all anodes off to prevent ghosting. Digits are captured as a whole frame
// at each scan wrap so a display never mixes old and new values.
module sevenseg_scan
    import stopwatch_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter logic [3:0]  DP_MASK      = 4'b1010,
    parameter bit          LZ_BLANK     = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    sevenseg_scan_if.slave bus
);

    localparam int unsigned   PW        = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] TC_VAL    = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_VAL = PW'(BLANK_CYCLES);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    bcd_t          shadow [4];
    logic          frame_valid;
    logic          tc;
    bcd_t          cur_digit;
    seg_t          cur_seg;
    logic [3:0]    an_next;

    assign tc = (presc == TC_VAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc       <= '0;
            idx         <= '0;
            frame_valid <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                shadow[i] <= '0;
            end
        end else if (tc) begin
            presc <= '0;
            idx   <= idx + 2'd1;
            if (idx == 2'd3) begin
                shadow[0]   <= bus.d0;
                shadow[1]   <= bus.d1;
                shadow[2]   <= bus.d2;
                shadow[3]   <= bus.d3;
                frame_valid <= 1'b1;
            end
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign cur_digit = shadow[idx];

    bcd_to_7seg u_dec (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    always_comb begin
        an_next = '1;
        if (presc >= BLANK_VAL &&
            !(LZ_BLANK && idx == 2'd3 && cur_digit == 4'd0)) begin
            an_next = ~(4'b0001 << idx);
        end
    end

    // The display stays dark until the first frame has been captured, so
    // the zeroed shadow digits after reset are never shown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.an  <= '1;
            bus.seg <= SEG_OFF;
            bus.dp  <= 1'b1;
        end else if (!frame_valid) begin
            bus.an  <= '1;
            bus.seg <= SEG_OFF;
            bus.dp  <= 1'b1;
        end else begin
            bus.an  <= an_next;
            bus.seg <= cur_seg;
            bus.dp  <= ~DP_MASK[idx];
        end
    end

endmodule
